// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: two requesters share one 16-bit shifter through a
// round-robin arbiter. The result sits in a single output register with a
// valid/ready handshake.
// Optional feature: define BARREL_SHIFT_ROTATE_EN to make op 11 a rotate right.
// When it is undefined, op 11 behaves as a logical right shift.
//
// state | meaning
// IDLE  | result register empty, res_valid = 0
// FULL  | result register holds an undelivered result, res_valid = 1
module barrel_shift_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    input  logic [1:0]  req1_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic [7:0]  ops_count
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        slot_free;
    logic        grant0, grant1;
    logic        accept;
    logic        handshake;
    logic [15:0] sel_data;
    logic [3:0]  sel_amt;
    logic [1:0]  sel_op;
    logic [15:0] shift_res;
`ifdef BARREL_SHIFT_ROTATE_EN
    logic [31:0] rot_wide;
`endif

    assign res_valid = (state == FULL);
    assign slot_free = !res_valid || res_ready;
    assign handshake = res_valid && res_ready;

    // Round-robin grant: a lone requester always wins. On a tie, the
    // requester that did not win last time gets the grant.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    // Readys stay low during reset so nothing is accepted while rst is high.
    always_comb begin
        req0_ready = !rst && slot_free && grant0;
        req1_ready = !rst && slot_free && grant1;
        accept     = req0_ready || req1_ready;
    end

    // Operand mux. Only the granted requester's fields reach the shifter.
    always_comb begin
        sel_data = req0_data;
        sel_amt  = req0_amt;
        sel_op   = req0_op;
        if (grant1) begin
            sel_data = req1_data;
            sel_amt  = req1_amt;
            sel_op   = req1_op;
        end
    end

    // Shared shifter. Every shift by 0 passes the operand through unchanged.
    always_comb begin
        shift_res = sel_data;
`ifdef BARREL_SHIFT_ROTATE_EN
        rot_wide  = {sel_data, sel_data} >> sel_amt;
`endif
        case (sel_op)
            2'b00:   shift_res = sel_data >> sel_amt;
            2'b01:   shift_res = sel_data << sel_amt;
            2'b10:   shift_res = $signed(sel_data) >>> sel_amt;
`ifdef BARREL_SHIFT_ROTATE_EN
            default: shift_res = rot_wide[15:0];
`else
            default: shift_res = sel_data >> sel_amt;
`endif
        endcase
    end

    // Next state. When a handshake and an accept happen in the same cycle,
    // the FSM stays in FULL, so the output can deliver one result per cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = FULL;
            FULL: begin
                if (accept)         state_nxt = FULL;
                else if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset throws away any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Result register and arbitration history. Both update only on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data   <= 16'h0000;
            res_id     <= 1'b0;
            last_grant <= !RR_INIT;
        end else if (accept) begin
            res_data   <= shift_res;
            res_id     <= grant1;
            last_grant <= grant1;
        end
    end

    // Count delivered results, wrapping at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ops_count <= 8'h00;
        else if (handshake) ops_count <= ops_count + 8'h01;
    end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester N has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each: requester N is accepted this cycle.
REQ-006 SHALL have ports req0_data/req1_data, input, 16 each: operand.
REQ-007 SHALL have ports req0_amt/req1_amt, input, 4 each: shift amount, 0-15.
REQ-008 SHALL have ports req0_op/req1_op, input, 2 each: 00 logical right, 01 left, 10 arithmetic right, 11 rotate right.
REQ-009 SHALL have port res_valid, output, 1: result register holds a valid result.
REQ-010 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port res_data, output, 16: shifted result.
REQ-012 SHALL have port res_id, output, 1: index of the requester that owns res_data.
REQ-013 SHALL have port ops_count, output, 8: number of results delivered, wrapping.

Function
REQ-014 SHALL share one 16-bit shift datapath between two requesters, with a single registered result stage.
REQ-015 SHALL define slot_free = !res_valid || res_ready and accept at most one request per cycle, only when slot_free.
REQ-016 SHALL arbitrate round-robin: if only one req valid, grant it; if both valid, grant the requester other than last_grant.
REQ-017 SHALL drive reqN_ready = slot_free && grantN, combinationally, with at most one ready high per cycle.
REQ-018 SHALL update last_grant only on an accepted transfer (valid && ready).
REQ-019 SHALL register res_data and res_id and set res_valid on the edge after acceptance: latency 1 cycle.
REQ-020 SHALL hold res_data, res_id and res_valid stable while res_valid && !res_ready.
REQ-021 SHALL clear res_valid on a res_ready handshake when no new request is accepted that cycle.
REQ-022 SHALL, when a handshake and an acceptance occur in the same cycle, load the new result with res_valid staying 1, giving full throughput of one result per cycle.
REQ-023 SHALL compute op 00 as zero-fill right shift, 01 as zero-fill left shift, and 10 as right shift filling with data[15].
REQ-024 SHALL pass the operand unchanged for amt 0 in every op.
REQ-025 SHALL increment ops_count by 1 on every res_valid && res_ready cycle, wrapping 255 -> 0.
REQ-026 SHALL implement an FSM with states IDLE (res_valid=0) and FULL (res_valid=1).
REQ-027 SHALL transition IDLE->FULL on accept; FULL->IDLE on handshake with no accept; FULL->FULL on stall or on handshake plus accept.
REQ-028 SHALL ignore reqN_data, reqN_amt and reqN_op whenever reqN_valid is 0.

Reset
REQ-029 SHALL, while rst=1, immediately force res_valid=0, res_data=0, res_id=0, ops_count=0, FSM=IDLE and last_grant=!RR_INIT, so that RR_INIT wins the first tie.
REQ-030 SHALL discard a result pending at reset assertion, so it is never delivered.
REQ-031 SHALL hold both reqN_ready at 0 while rst=1, and accept nothing.

Configuration
REQ-032 SHALL provide macro BARREL_SHIFT_ROTATE_EN; when defined, op 11 SHALL rotate right by amt, so that bits shifted out of bit 0 re-enter at bit 15.
REQ-033 SHALL, when BARREL_SHIFT_ROTATE_EN is undefined, execute op 11 as logical right shift (op 00), with no rotate logic synthesized.

Verification
REQ-034 SHALL check: req0 only, data=16'hDAEA, amt=2, op=00 -> one cycle later res_valid=1, res_data=16'h36BA, res_id=0.
REQ-035 SHALL check: req1 only, data=16'hDAEA, op=10, amt=4 -> res_data=16'hFDAE; then op=01, amt=8 -> res_data=16'hEA00.
REQ-036 SHALL check: both valid every cycle with res_ready=1 from reset, RR_INIT=0 -> res_id sequence 0,1,0,1, one result per cycle, ops_count=4 after 4 results.
REQ-037 SHALL check: res_ready=0 for 5 cycles with a result pending -> res_data and res_id stable, both readys 0, ops_count unchanged.
REQ-038 SHALL check: op=11, amt=15, data=16'hDAEA -> 16'hB5D5 with BARREL_SHIFT_ROTATE_EN and 16'h0001 without.
REQ-039 SHALL check: rst pulse while FULL -> res_valid=0 asynchronously, ops_count=0, and no stale result after release.
